// File: rtl/rr_arbiter_four.sv
// Four-requester round-robin arbiter: one-hot grant plus 2-bit owner index, held until release.
// Define ARB_TIMEOUT_EN to revoke a grant held for MAX_HOLD cycles and pulse timeout.
module rr_arbiter_four #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] pick;
  logic       pick_ok;

  if (MAX_HOLD < 1 || MAX_HOLD >= 2 ** CNT_W) begin : g_bad_max_hold
    $error("rr_arbiter_four: MAX_HOLD must be in 1..2**CNT_W-1");
  end

  // Search starts just after the last owner, so the previous owner is tried last.
  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_ok) begin
            gnt       <= 4'b0001 << pick;
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
            last      <= pick;
            hold_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Normal release is tested first so it wins on the limit cycle.
          if (!req[gnt_idx]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_ok) begin
            gnt       <= 4'b0001 << pick;
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
            last      <= pick;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!req[gnt_idx]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_four.sv
// Directed bench for rr_arbiter_four: per-cycle vector table plus hold-limit sequences.
module tb_rr_arbiter_four;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_four #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic e, input logic [3:0] rq,
                     input logic [3:0] g, input logic [1:0] i, input logic v);
    vec_t x;
    x.rst = r; x.en = e; x.req = rq; x.gnt = g; x.idx = i; x.valid = v;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [3:0] rq);
    @(negedge clk);
    rst = r; enable = e; req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic t);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".gnt_idx"}, {2'b00, gnt_idx}, {2'b00, i});
    chk({tag, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, v});
    chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, t});
  endtask

  initial begin
    //  rst en  req      gnt      idx  valid
    add(1, 1, 4'b0000, 4'b0000, 2'd0, 0);  // reset
    add(0, 1, 4'b0001, 4'b0001, 2'd0, 1);  // first grant
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);  // drop -> release
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 1, 4'b0000, 4'b0000, 2'd0, 0);  // re-reset, pointer back to 3
    add(0, 1, 4'b1111, 4'b0001, 2'd0, 1);  // rotation 0
    add(0, 1, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 1, 4'b1110, 4'b0000, 2'd0, 0);  // release
    add(0, 1, 4'b1111, 4'b0010, 2'd1, 1);  // rotation 1
    add(0, 1, 4'b1111, 4'b0010, 2'd1, 1);
    add(0, 1, 4'b1101, 4'b0000, 2'd1, 0);
    add(0, 1, 4'b1111, 4'b0100, 2'd2, 1);  // rotation 2
    add(0, 1, 4'b1111, 4'b0100, 2'd2, 1);
    add(0, 1, 4'b1011, 4'b0000, 2'd2, 0);
    add(0, 1, 4'b1111, 4'b1000, 2'd3, 1);  // rotation 3
    add(0, 1, 4'b1111, 4'b1000, 2'd3, 1);
    add(0, 1, 4'b0111, 4'b0000, 2'd3, 0);
    add(0, 1, 4'b1111, 4'b0001, 2'd0, 1);  // wrap to 0
    add(0, 1, 4'b1110, 4'b0000, 2'd0, 0);
    add(0, 1, 4'b1000, 4'b1000, 2'd3, 1);  // last=0 -> 3 wins
    add(0, 1, 4'b0000, 4'b0000, 2'd3, 0);
    add(0, 1, 4'b1001, 4'b0001, 2'd0, 1);  // last=3 -> 0 before 3
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 4'b0100, 4'b0000, 2'd0, 0);  // enable low blocks grant
    add(0, 1, 4'b0100, 4'b0100, 2'd2, 1);  // enable raised
    add(0, 0, 4'b0101, 4'b0100, 2'd2, 1);  // enable low / extra req ignored while BUSY
    add(0, 0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 0, 4'b0001, 4'b0000, 2'd2, 0);  // no grant with enable low
    add(0, 1, 4'b0010, 4'b0010, 2'd1, 1);
    add(0, 1, 4'b0010, 4'b0010, 2'd1, 1);
    add(1, 1, 4'b0010, 4'b0000, 2'd0, 0);  // reset mid-grant
    add(0, 1, 4'b0011, 4'b0001, 2'd0, 1);  // pointer back to 3 -> 0 first
    add(0, 1, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);

    foreach (vt[n]) begin
      step(vt[n].rst, vt[n].en, vt[n].req);
      chk_all($sformatf("vec%0d", n), vt[n].gnt, vt[n].idx, vt[n].valid, 1'b0);
    end

    step(1, 1, 4'b0000);
    chk_all("hold_reset", 4'b0000, 2'd0, 0, 0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step(0, 1, 4'b0011);
      chk_all($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1, 0);
    end
    step(0, 1, 4'b0011);
    chk_all("revoke", 4'b0000, 2'd0, 0, 1);
    step(0, 1, 4'b0011);
    chk_all("after_revoke", 4'b0010, 2'd1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 4'b0011);
      chk_all($sformatf("hold2_c%0d", c), 4'b0010, 2'd1, 1, 0);
    end
    step(0, 1, 4'b0000);
    chk_all("release_on_limit", 4'b0000, 2'd1, 0, 0);
    step(0, 1, 4'b0000);
    chk_all("idle_after_limit", 4'b0000, 2'd1, 0, 0);
`else
    for (int c = 0; c < 22; c++) begin
      step(0, 1, 4'b0011);
      chk_all($sformatf("nolimit_c%0d", c), 4'b0001, 2'd0, 1, 0);
    end
    step(0, 1, 4'b0000);
    chk_all("nolimit_release", 4'b0000, 2'd0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
